// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation feeding a small {pc, inst} FIFO.
// One-cycle fetch-to-output latency; IF/ID stalls fill the queue, and the PC only holds once it is full.
module if_fetch_queue #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INST_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    FQ_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid,
    input  logic [ADDR_WIDTH-1:0]       redirect_addr,
    output logic [ADDR_WIDTH-1:0]       imem_addr,
    output logic                        imem_req,
    input  logic [INST_WIDTH-1:0]       imem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_WIDTH-1:0]       out_pc,
    output logic [INST_WIDTH-1:0]       out_inst,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q   [FQ_DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [FQ_DEPTH];
    logic                  pop;
    logic                  fetch;

    // A pending redirect hides the stale head so IF/ID never consumes wrong-path work.
    assign out_valid = (count_q != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    // A full queue may still fetch when the head leaves in the same cycle.
    assign fetch     = !redirect_valid && ((count_q < CW'(FQ_DEPTH)) || pop);

    assign imem_addr = fetch_pc_q;
    assign imem_req  = fetch;
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign fq_count  = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
            rd_ptr_d   = wr_ptr_q;
            count_d    = '0;
        end else begin
            if (fetch) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({fetch, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_VECTOR;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry contents need no reset: they are only visible once count marks them valid.
    always_ff @(posedge clk) begin
        if (fetch) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  fq_count;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] sb [$];

    if_fetch_queue #(
        .ADDR_WIDTH   (32),
        .INST_WIDTH   (32),
        .RESET_VECTOR (32'h0000_0100),
        .FQ_DEPTH     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    // Combinational instruction memory: content is a fixed function of the address.
    assign imem_rdata = imem_addr ^ 32'h1357_9BDF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        tick();
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (fq_count !== 3'd0) $display("FAIL reset_fq_count got %0d want 0", fq_count); else n_pass++;
        n_total++; if (imem_addr !== 32'h100) $display("FAIL reset_imem_addr got %h want 00000100", imem_addr); else n_pass++;
        n_total++; if (imem_req !== 1'b1) $display("FAIL reset_imem_req got %0b want 1", imem_req); else n_pass++;
        redirect_valid = 1'b1;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req_redirect got %0b want 0", imem_req); else n_pass++;
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(4 * i));
        out_ready = 1'b1;
        rst = 1'b0;
        #1;
        n_total++; if (imem_addr !== 32'h100) $display("FAIL stream_first_addr got %h want 00000100", imem_addr); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL stream_first_valid got %0b want 0", out_valid); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_total++; if (imem_addr !== 32'h100 + 32'(4 * i)) $display("FAIL stream_addr cycle %0d got %h want %h", i, imem_addr, 32'h100 + 32'(4 * i)); else n_pass++;
            n_total++; if (fq_count !== 3'd1) $display("FAIL stream_count cycle %0d got %0d want 1", i, fq_count); else n_pass++;
        end
        tick();
        out_ready = 1'b0;
        n_total++; if (sb.size() != 0) $display("FAIL stream_drained got %0d left want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 8; i++) sb.push_back(32'h100 + 32'(4 * i));
        rst = 1'b0;
        repeat (4) tick();
        for (int c = 0; c < 2; c++) begin
            n_total++; if (fq_count !== 3'd4) $display("FAIL full_count got %0d want 4", fq_count); else n_pass++;
            n_total++; if (imem_req !== 1'b0) $display("FAIL full_req got %0b want 0", imem_req); else n_pass++;
            n_total++; if (imem_addr !== 32'h110) $display("FAIL full_addr got %h want 00000110", imem_addr); else n_pass++;
            n_total++; if (out_pc !== 32'h100) $display("FAIL stall_pc got %h want 00000100", out_pc); else n_pass++;
            if (c == 0) tick();
        end
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            n_total++; if (fq_count !== 3'd4) $display("FAIL fullpop_count k=%0d got %0d want 4", k, fq_count); else n_pass++;
            n_total++; if (imem_req !== 1'b1) $display("FAIL fullpop_req k=%0d got %0b want 1", k, imem_req); else n_pass++;
            n_total++; if (imem_addr !== 32'h110 + 32'(4 * k)) $display("FAIL fullpop_addr k=%0d got %h want %h", k, imem_addr, 32'h110 + 32'(4 * k)); else n_pass++;
            tick();
        end
        out_ready = 1'b0;
        #1;
        n_total++; if (imem_addr !== 32'h130) $display("FAIL refill_addr got %h want 00000130", imem_addr); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL refill_req got %0b want 0", imem_req); else n_pass++;
        n_total++; if (sb.size() != 0) $display("FAIL fill_drained got %0d left want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        rst = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h2003;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL redir_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL redir_req got %0b want 0", imem_req); else n_pass++;
        tick();
        redirect_valid = 1'b0;
        sb.push_back(32'h2000);
        sb.push_back(32'h2004);
        out_ready = 1'b1;
        #1;
        n_total++; if (fq_count !== 3'd0) $display("FAIL redir_flush_count got %0d want 0", fq_count); else n_pass++;
        n_total++; if (imem_addr !== 32'h2000) $display("FAIL redir_target got %h want 00002000", imem_addr); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL redir_empty_valid got %0b want 0", out_valid); else n_pass++;
        tick();
        n_total++; if (fq_count !== 3'd1) $display("FAIL redir_count got %0d want 1", fq_count); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL redir_out_valid got %0b want 1", out_valid); else n_pass++;
        tick();
        tick();
        out_ready = 1'b0;
        n_total++; if (sb.size() != 0) $display("FAIL redir_drained got %0d left want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        rst = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        sb.push_back(32'hFFFF_FFF8);
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0000_0000);
        out_ready = 1'b1;
        #1;
        n_total++; if (imem_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_addr0 got %h want fffffff8", imem_addr); else n_pass++;
        tick();
        n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr1 got %h want fffffffc", imem_addr); else n_pass++;
        tick();
        n_total++; if (imem_addr !== 32'h0000_0000) $display("FAIL wrap_addr2 got %h want 00000000", imem_addr); else n_pass++;
        tick();
        n_total++; if (imem_addr !== 32'h0000_0004) $display("FAIL wrap_addr3 got %h want 00000004", imem_addr); else n_pass++;
        tick();
        out_ready = 1'b0;
        n_total++; if (sb.size() != 0) $display("FAIL wrap_drained got %0d left want 0", sb.size()); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_total++; if (fq_count !== 3'd3) $display("FAIL arst_pre_count got %0d want 3", fq_count); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %0b want 0", out_valid); else n_pass++;
        n_total++; if (fq_count !== 3'd0) $display("FAIL arst_count got %0d want 0", fq_count); else n_pass++;
        n_total++; if (imem_addr !== 32'h100) $display("FAIL arst_addr got %h want 00000100", imem_addr); else n_pass++;
        tick();
        rst = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b1) $display("FAIL arst_resume_req got %0b want 1", imem_req); else n_pass++;
        tick();
        n_total++; if (fq_count !== 3'd1) $display("FAIL arst_resume_count got %0d want 1", fq_count); else n_pass++;
        n_total++; if (out_pc !== 32'h100) $display("FAIL arst_resume_pc got %h want 00000100", out_pc); else n_pass++;
        n_total++; if (out_inst !== (32'h100 ^ 32'h1357_9BDF)) $display("FAIL arst_resume_inst got %h want %h", out_inst, 32'h100 ^ 32'h1357_9BDF); else n_pass++;
        n_total++; if (imem_addr !== 32'h104) $display("FAIL arst_resume_addr got %h want 00000104", imem_addr); else n_pass++;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    n_total++;
                    if (sb.size() == 0) begin
                        $display("FAIL sb_unexpected_pop got pc %h want no pop", out_pc);
                    end else begin
                        logic [31:0] exp_pc;
                        exp_pc = sb.pop_front();
                        if (out_pc !== exp_pc || out_inst !== (exp_pc ^ 32'h1357_9BDF))
                            $display("FAIL sb_pop got pc %h inst %h want pc %h inst %h",
                                     out_pc, out_inst, exp_pc, exp_pc ^ 32'h1357_9BDF);
                        else
                            n_pass++;
                    end
                end
            end
        join_none

        test_reset();
        test_stream();
        test_fill_drain();
        test_redirect();
        test_wrap();
        test_async_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch front end that replaces the single-register PC stage. It generates sequential fetch addresses from a configurable reset vector and reads a combinational instruction memory. Fetched {pc, instruction} pairs are buffered in a small FIFO so that IF/ID back-pressure no longer freezes the PC. A redirect from EX/MEM flushes the queue and restarts fetch at the target.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PC and memory address
- INST_WIDTH, 32, instruction width
- RESET_VECTOR, 0, first fetch address after reset; must be 4-byte aligned
- FQ_DEPTH, 4, queue entries; power of two, ≥ 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  taken branch/jump from EX/MEM
- redirect_addr  in  ADDR_WIDTH  redirect target
- imem_addr  out  ADDR_WIDTH  current fetch PC to instruction memory
- imem_req  out  1  fetch performed this cycle
- imem_rdata  in  INST_WIDTH  instruction at imem_addr, same cycle (combinational memory)
- out_valid  out  1  head entry available to IF/ID
- out_ready  in  1  IF/ID accepts head (low = hazard stall)
- out_pc  out  ADDR_WIDTH  PC of head entry
- out_inst  out  INST_WIDTH  instruction of head entry
- fq_count  out  $clog2(FQ_DEPTH)+1  occupied entries

## Operation
- State: fetch_pc register, FQ_DEPTH-entry storage of {pc, inst}, rd_ptr, wr_ptr, count.
- Define pop = out_valid & out_ready.
- Define fetch = !redirect_valid & (count < FQ_DEPTH | pop).
- Outputs:
  - imem_addr = fetch_pc.
  - imem_req = fetch.
  - out_valid = (count != 0) & !redirect_valid.
  - out_pc/out_inst = entry at rd_ptr.
  - fq_count = count.
- Fetch cycle: write {fetch_pc, imem_rdata} at wr_ptr. Then wr_ptr++ and fetch_pc <= fetch_pc + 4.
- Pop cycle: rd_ptr++.
- Count: +1 on fetch-only, -1 on pop-only, unchanged when both occur.
- Redirect cycle:
  - count <= 0 and rd_ptr <= wr_ptr; all buffered entries are discarded.
  - fetch_pc <= {redirect_addr[ADDR_WIDTH-1:2], 2'b00}, i.e. low two bits forced to zero.
  - No push, no pop.
  - Redirect has priority over every other event.
- Full and not popping: fetch_pc holds and imem_req=0.
- Empty: out_valid=0 and out_ready is ignored.
- Arithmetic:
  - fetch_pc + 4 wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC → 0x00000000 at 32 bits).
  - Pointers wrap modulo FQ_DEPTH.
- No startup bubble: the first post-reset cycle fetches RESET_VECTOR.

## Timing
- Reset, asynchronous and immediate:
  - fetch_pc=RESET_VECTOR, count=0, pointers=0.
  - Outputs: out_valid=0, fq_count=0, imem_addr=RESET_VECTOR. imem_req evaluates combinationally to 1 unless redirect_valid is asserted.
  - Entry contents are don't-care.
- Reset mid-operation discards all entries and fetch_pc immediately, with no partial updates.
- Latency: an instruction fetched in cycle N is visible at out_* in cycle N+1 if the queue was empty.
- Steady state with out_ready=1: one instruction per cycle, count stays 1.
- Redirect in cycle N:
  - out_valid=0 in N.
  - Fetch of redirect target in N+1.
  - Target instruction at out_* in N+2.
- Full with a pop in the same cycle: push and pop both occur, count stays FQ_DEPTH, no throughput loss.
- out_* must stay stable while out_valid=1 and out_ready=0.

## Test plan
- Reset release, RESET_VECTOR=0x100, out_ready=1 → imem_addr 0x100, 0x104, 0x108 on successive cycles; out_pc lags by one cycle; fq_count=1 steady.
- out_ready=0 from reset, FQ_DEPTH=4 → four fetches (0x0–0xC), fq_count=4, imem_req=0, imem_addr holds 0x10. Raise out_ready → out_pc 0x0, 0x4, 0x8, 0xC, 0x10 back-to-back with no gap.
- Full queue, redirect_valid=1 with redirect_addr=0x2003 → out_valid=0 that cycle, fq_count=0 next cycle, imem_addr=0x2000, out_pc=0x2000 two cycles after redirect.
- Full queue, out_ready=1 continuous → fq_count stays 4, one entry per cycle, PCs strictly +4.
- fetch_pc=0xFFFFFFF8, ADDR_WIDTH=32 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert rst asynchronously mid-cycle with 3 entries queued → out_valid and fq_count drop to 0 immediately (before the next edge), imem_addr=RESET_VECTOR; normal fetch resumes on the first edge after release.
